// File: rtl/luks_sample_buffer.sv
// luks_sample_buffer: paces light-sensor SPI conversions, captures each 8-bit
// reading into a ring buffer drained through a simple read port.
// Optional moving average over the last 2^DEPTH_LOG2 readings: define LUKS_AVG_EN.
module luks_sample_buffer #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  spi_ready,
  input  logic [7:0]            spi_data,
  output logic                  spi_valid,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  timeout_err
`ifdef LUKS_AVG_EN
  ,
  output logic [7:0]            avg,
  output logic                  avg_valid
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam int unsigned PW    = $clog2(PERIOD + 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]            state;
  logic                  ready_q;
  logic [TW-1:0]         tcnt;
  logic [PW-1:0]         wcnt;
  logic                  capture;
  logic                  req_timeout;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  do_rd;
  logic                  overwrite;

  // Capture on a rising spi_ready while requesting; timeout after TIMEOUT cycles of spi_valid.
  always_comb begin
    capture     = (state == REQ) && spi_ready && !ready_q;
    req_timeout = (state == REQ) && !capture && spi_valid && (tcnt == TW'(TIMEOUT - 1));
  end

  // Request sequencer. tcnt counts only cycles with spi_valid already high, so
  // the request is visible for exactly TIMEOUT cycles. WAIT leaves on wcnt==1
  // because the REQ entry edge adds one cycle before spi_valid rises, keeping
  // the request spacing at PERIOD cycles from the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      spi_valid   <= 1'b0;
      ready_q     <= 1'b0;
      tcnt        <= '0;
      wcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      ready_q <= spi_ready;
      case (state)
        IDLE: begin
          spi_valid <= 1'b0;
          tcnt      <= '0;
          if (enable) state <= REQ;
        end
        REQ: begin
          if (capture || req_timeout) begin
            state     <= WAIT;
            spi_valid <= 1'b0;
            wcnt      <= PW'(PERIOD - 1);
            if (req_timeout) timeout_err <= 1'b1;
          end else begin
            spi_valid <= 1'b1;
            if (spi_valid) tcnt <= tcnt + 1'b1;
          end
        end
        WAIT: begin
          spi_valid <= 1'b0;
          if (wcnt <= PW'(1)) begin
            tcnt  <= '0;
            state <= enable ? REQ : IDLE;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          spi_valid <= 1'b0;
        end
      endcase
    end
  end

  // Buffer control decisions and next occupancy.
  always_comb begin
    do_rd      = rd_en && !empty;
    overwrite  = capture && full && !do_rd;
    count_next = count;
    if (capture && !do_rd && !full)
      count_next = count + 1'b1;
    else if (do_rd && !capture)
      count_next = count - 1'b1;
  end

  // Sample storage; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (!rst && capture) mem[wptr] <= spi_data;
  end

  // Ring-buffer pointers, occupancy, flags and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[rptr];
      if (capture) wptr <= wptr + 1'b1;
      if (do_rd || overwrite) rptr <= rptr + 1'b1;
      if (overwrite) overflow <= 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_CNT);
    end
  end

`ifdef LUKS_AVG_EN
  logic [7:0]            hist [DEPTH];
  logic [DEPTH_LOG2-1:0] hptr;
  logic [DEPTH_LOG2+7:0] sum;
  logic [DEPTH_LOG2:0]   hfill;
  logic                  cap_q;

  // Running window sum; avg/avg_valid follow one edge after each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
      hptr      <= '0;
      sum       <= '0;
      hfill     <= '0;
      cap_q     <= 1'b0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      cap_q <= capture;
      if (capture) begin
        sum        <= sum + {{DEPTH_LOG2{1'b0}}, spi_data} - {{DEPTH_LOG2{1'b0}}, hist[hptr]};
        hist[hptr] <= spi_data;
        hptr       <= hptr + 1'b1;
        if (hfill != FULL_CNT) hfill <= hfill + 1'b1;
      end
      if (cap_q) begin
        avg <= sum[DEPTH_LOG2 +: 8];
        if (hfill == FULL_CNT) avg_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
